// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared types, default widths and saturating-add helper for psum_acc
package psum_pkg;

    localparam int M_BW   = 16;
    localparam int AK_BW  = 20;
    localparam int KSIZE  = 9;
    localparam int CNT_BW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } psum_state_e;

    // Returns {ovf, sum}; sum clamps to all-ones when the carry-out is set.
    function automatic logic [AK_BW:0] sat_add(input logic [AK_BW-1:0] acc,
                                               input logic [M_BW-1:0]  prod);
        logic [AK_BW:0] s;
        s = {1'b0, acc} + {{(AK_BW+1-M_BW){1'b0}}, prod};
        return s[AK_BW] ? {1'b1, {AK_BW{1'b1}}} : s;
    endfunction

endpackage

// File: rtl/psum_acc_sat_adder.sv
// rtl/psum_acc_sat_adder.sv - combinational AK_BW+1-bit adder clamping to 2^AK_BW-1
module sat_adder #(
    parameter int M_BW  = psum_pkg::M_BW,
    parameter int AK_BW = psum_pkg::AK_BW
) (
    input  logic [AK_BW-1:0] acc,
    input  logic [M_BW-1:0]  prod,
    output logic [AK_BW-1:0] sum,
    output logic             ovf
);

    logic [AK_BW:0] full;

    assign full = {1'b0, acc} + {{(AK_BW+1-M_BW){1'b0}}, prod};
    assign ovf  = full[AK_BW];
    assign sum  = full[AK_BW] ? {AK_BW{1'b1}} : full[AK_BW-1:0];

endmodule

// File: rtl/psum_acc.sv
// rtl/psum_acc.sv - sums KSIZE valid products per window and holds the result on a valid/ready port
module psum_acc #(
    parameter int M_BW   = psum_pkg::M_BW,
    parameter int AK_BW  = psum_pkg::AK_BW,
    parameter int KSIZE  = psum_pkg::KSIZE,
    parameter int CNT_BW = psum_pkg::CNT_BW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [M_BW-1:0]   i_prod,
    input  logic              i_prod_vld,
    input  logic              i_clear,
    output logic              o_busy,
    output logic [AK_BW-1:0]  o_psum,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_ovf,
    output logic [CNT_BW-1:0] o_cnt
);
    import psum_pkg::*;

    localparam logic [CNT_BW-1:0] KSIZE_C = CNT_BW'(KSIZE);

    psum_state_e       state;
    logic [AK_BW-1:0]  acc;
    logic [CNT_BW-1:0] cnt;
    logic              ovf;
    logic              valid_q;
    logic              busy_q;

    logic [AK_BW-1:0]  add_sum;
    logic              add_ovf;
    logic [CNT_BW-1:0] cnt_nxt;

    sat_adder #(.M_BW(M_BW), .AK_BW(AK_BW)) u_sat_adder (
        .acc  (acc),
        .prod (i_prod),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    assign cnt_nxt = cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_clear) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end else if (i_prod_vld) begin
                        acc <= AK_BW'(i_prod);
                        cnt <= CNT_BW'(1);
                        ovf <= 1'b0;
                        if (KSIZE == 1) begin
                            state   <= ST_DONE;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (i_clear) begin
                        state <= ST_IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end else if (i_prod_vld) begin
                        acc <= add_sum;
                        cnt <= cnt_nxt;
                        ovf <= ovf | add_ovf;
                        if (cnt_nxt == KSIZE_C) begin
                            state   <= ST_DONE;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Completed results survive i_clear; only the handshake releases them.
                    if (i_ready) begin
                        state   <= ST_IDLE;
                        acc     <= '0;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    acc     <= '0;
                    cnt     <= '0;
                    ovf     <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_psum  = acc;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_ovf   = ovf;
    assign o_cnt   = cnt;

endmodule

// File: tb/tb_psum_acc.sv
// tb/tb_psum_acc.sv - directed self-checking bench for psum_acc (KSIZE=9 and KSIZE=20 instances)
module tb_psum_acc;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [15:0] prod;
    logic        vld, clr, rdy;
    logic        busy, valid, ovf;
    logic [19:0] psum;
    logic [7:0]  cnt;

    logic [15:0] b_prod;
    logic        b_vld, b_clr, b_rdy;
    logic        b_busy, b_valid, b_ovf;
    logic [19:0] b_psum;
    logic [7:0]  b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    psum_acc dut (
        .clk(clk), .rst_n(rst_n), .i_prod(prod), .i_prod_vld(vld), .i_clear(clr),
        .o_busy(busy), .o_psum(psum), .o_valid(valid), .i_ready(rdy),
        .o_ovf(ovf), .o_cnt(cnt)
    );

    psum_acc #(.KSIZE(20)) dut_k20 (
        .clk(clk), .rst_n(rst_n), .i_prod(b_prod), .i_prod_vld(b_vld), .i_clear(b_clr),
        .o_busy(b_busy), .o_psum(b_psum), .o_valid(b_valid), .i_ready(b_rdy),
        .o_ovf(b_ovf), .o_cnt(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] p, input logic v, input logic c);
        prod = p; vld = v; clr = c;
        @(posedge clk); #1;
        vld = 1'b0; clr = 1'b0;
    endtask

    task automatic push_b(input logic [15:0] p, input logic v);
        b_prod = p; b_vld = v;
        @(posedge clk); #1;
        b_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        prod = '0; vld = 0; clr = 0; rdy = 1;
        b_prod = '0; b_vld = 0; b_clr = 0; b_rdy = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_psum", 32'(psum), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_cnt", 32'(cnt), 0);
        rst_n = 1'b1;

        // basic window: 9 x 10
        for (int i = 0; i < 8; i++) push(16'd10, 1, 0);
        check("basic_cnt8", 32'(cnt), 8);
        check("basic_nvalid8", 32'(valid), 0);
        push(16'd10, 1, 0);
        check("basic_valid", 32'(valid), 1);
        check("basic_busy", 32'(busy), 1);
        check("basic_psum", 32'(psum), 90);
        check("basic_cnt", 32'(cnt), 9);
        check("basic_ovf", 32'(ovf), 0);
        push(16'd0, 0, 0);
        check("basic_drain_valid", 32'(valid), 0);
        check("basic_drain_busy", 32'(busy), 0);
        check("basic_drain_cnt", 32'(cnt), 0);

        // gapped input 1..9
        for (int i = 1; i <= 9; i++) begin
            push(16'(i), 1, 0);
            if (i < 9) begin
                push(16'd99, 0, 0);
                check("gap_cnt_hold", 32'(cnt), 32'(i));
            end
        end
        check("gap_valid", 32'(valid), 1);
        check("gap_psum", 32'(psum), 45);
        push(16'd0, 0, 0);
        check("gap_drain", 32'(valid), 0);

        // backpressure: window of 9 x 3 held while 7s are presented
        rdy = 0;
        for (int i = 0; i < 9; i++) push(16'd3, 1, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_busy", 32'(busy), 1);
            check("bp_psum", 32'(psum), 27);
            check("bp_cnt", 32'(cnt), 9);
            push(16'd7, 1, 0);
        end
        rdy = 1;
        push(16'd7, 1, 0);
        check("bp_drain_valid", 32'(valid), 0);
        check("bp_drain_psum", 32'(psum), 0);
        check("bp_drain_cnt", 32'(cnt), 0);
        push(16'd4, 1, 0);
        check("bp_restart_cnt", 32'(cnt), 1);
        check("bp_restart_psum", 32'(psum), 4);
        for (int i = 0; i < 8; i++) push(16'd4, 1, 0);
        check("bp_next_psum", 32'(psum), 36);
        push(16'd0, 0, 0);

        // saturation boundary: 9 x FFFF fits, 20 x FFFF clamps
        for (int i = 0; i < 9; i++) push(16'hFFFF, 1, 0);
        check("nosat_psum", 32'(psum), 589815);
        check("nosat_ovf", 32'(ovf), 0);
        push(16'd0, 0, 0);
        for (int i = 0; i < 16; i++) push_b(16'hFFFF, 1);
        check("k20_16_psum", 32'(b_psum), 1048560);
        check("k20_16_ovf", 32'(b_ovf), 0);
        push_b(16'hFFFF, 1);
        check("k20_17_ovf", 32'(b_ovf), 1);
        for (int i = 0; i < 3; i++) push_b(16'hFFFF, 1);
        check("sat_valid", 32'(b_valid), 1);
        check("sat_psum", 32'(b_psum), 32'hFFFFF);
        check("sat_ovf", 32'(b_ovf), 1);
        check("sat_cnt", 32'(b_cnt), 20);
        push_b(16'd0, 0);
        for (int i = 0; i < 20; i++) push_b(16'd1, 1);
        check("sat_next_psum", 32'(b_psum), 20);
        check("sat_next_ovf", 32'(b_ovf), 0);
        push_b(16'd0, 0);

        // clear after 4, clear with product, then clear in DONE
        for (int i = 0; i < 4; i++) push(16'd2, 1, 0);
        check("clr_pre_cnt", 32'(cnt), 4);
        push(16'd0, 0, 1);
        check("clr_cnt", 32'(cnt), 0);
        check("clr_psum", 32'(psum), 0);
        push(16'd50, 1, 1);
        check("clr_vld_cnt", 32'(cnt), 0);
        check("clr_vld_psum", 32'(psum), 0);
        rdy = 0;
        for (int i = 0; i < 9; i++) push(16'd2, 1, 0);
        check("clr_win_psum", 32'(psum), 18);
        check("clr_win_valid", 32'(valid), 1);
        push(16'd0, 0, 1);
        check("clr_done_valid", 32'(valid), 1);
        check("clr_done_psum", 32'(psum), 18);
        check("clr_done_cnt", 32'(cnt), 9);
        rdy = 1;
        push(16'd0, 0, 0);
        check("clr_done_drain", 32'(valid), 0);

        // async reset mid-window
        for (int i = 0; i < 5; i++) push(16'd10, 1, 0);
        check("ar_pre_psum", 32'(psum), 50);
        #2 rst_n = 1'b0;
        #1;
        check("ar_psum", 32'(psum), 0);
        check("ar_cnt", 32'(cnt), 0);
        check("ar_valid", 32'(valid), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_ovf", 32'(ovf), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        push(16'd6, 1, 0);
        check("ar_idle_cnt", 32'(cnt), 1);
        check("ar_idle_psum", 32'(psum), 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
